// File: rtl/wb_mux_n.sv
// N-port Wishbone address-decoding multiplexer with a registered decode stage,
// per-access timeout / decode-error responses and sticky error capture.
module wb_mux_n #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMR_W          = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            wb_master_adr_i,
  input  logic [DATA_WIDTH-1:0]            wb_master_dat_i,
  input  logic                             wb_master_we_i,
  input  logic [SELECT_WIDTH-1:0]          wb_master_sel_i,
  input  logic                             wb_master_stb_i,
  input  logic                             wb_master_cyc_i,
  output logic [DATA_WIDTH-1:0]            wb_master_dat_o,
  output logic                             wb_master_ack_o,
  output logic                             wb_master_err_o,
  output logic                             wb_master_rty_o,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] wb_slave_adr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] wb_slave_dat_o,
  output logic [NUM_SLAVES-1:0]            wb_slave_we_o,
  output logic [NUM_SLAVES*SELECT_WIDTH-1:0] wb_slave_sel_o,
  output logic [NUM_SLAVES-1:0]            wb_slave_stb_o,
  output logic [NUM_SLAVES-1:0]            wb_slave_cyc_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wb_slave_dat_i,
  input  logic [NUM_SLAVES-1:0]            wb_slave_ack_i,
  input  logic [NUM_SLAVES-1:0]            wb_slave_err_i,
  input  logic [NUM_SLAVES-1:0]            wb_slave_rty_i,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_addr,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_addr_msk,
  output logic                             err_valid,
  output logic [ADDR_WIDTH-1:0]            err_addr,
  output logic [1:0]                       err_cause,
  input  logic                             err_clear
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DECERR = 2'd2;
  localparam logic [1:0] TOERR  = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [SEL_W-1:0]      sel_reg, sel_next;
  logic [TMR_W-1:0]      timer_reg, timer_next;
  logic                  err_valid_reg;
  logic [ADDR_WIDTH-1:0] err_addr_reg;
  logic [1:0]            err_cause_reg;

  logic [NUM_SLAVES-1:0] match;
  logic [NUM_SLAVES-1:0] is_sel;
  logic [SEL_W-1:0]      winner;
  logic                  any_match;
  logic                  req;
  logic                  in_err_state;
  logic                  sl_ack, sl_err, sl_rty;
  logic [DATA_WIDTH-1:0] sl_dat;
  logic                  term;
  logic                  timeout_hit;
  logic                  capture;

  assign req          = wb_master_cyc_i & wb_master_stb_i;
  assign any_match    = |match;
  assign in_err_state = rst_n && ((state_reg == DECERR) || (state_reg == TOERR));

  // Per-slave decode, broadcast and control gating; only the locked slave sees cyc/stb/we.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign match[gi] = ~|((wb_master_adr_i ^ wbs_addr[gi*ADDR_WIDTH +: ADDR_WIDTH])
                            & wbs_addr_msk[gi*ADDR_WIDTH +: ADDR_WIDTH]);
      assign is_sel[gi] = rst_n && (state_reg == ACTIVE) && (sel_reg == SEL_W'(gi));
      assign wb_slave_adr_o[gi*ADDR_WIDTH +: ADDR_WIDTH]     = wb_master_adr_i;
      assign wb_slave_dat_o[gi*DATA_WIDTH +: DATA_WIDTH]     = wb_master_dat_i;
      assign wb_slave_sel_o[gi*SELECT_WIDTH +: SELECT_WIDTH] = wb_master_sel_i;
      assign wb_slave_cyc_o[gi] = is_sel[gi] & wb_master_cyc_i;
      assign wb_slave_stb_o[gi] = is_sel[gi] & wb_master_stb_i;
      assign wb_slave_we_o[gi]  = is_sel[gi] & wb_master_we_i;
    end
  endgenerate

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timeout
      assign timeout_hit = (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Descending scan so the lowest matching index is the final assignment.
  always_comb begin
    winner = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (match[k]) winner = SEL_W'(k);
    end
  end

  always_comb begin
    sl_ack = 1'b0;
    sl_err = 1'b0;
    sl_rty = 1'b0;
    sl_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (is_sel[k]) begin
        sl_ack = wb_slave_ack_i[k];
        sl_err = wb_slave_err_i[k];
        sl_rty = wb_slave_rty_i[k];
        sl_dat = wb_slave_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign term            = req & (sl_ack | sl_err | sl_rty);
  assign wb_master_ack_o = req & sl_ack;
  assign wb_master_err_o = req & (sl_err | in_err_state);
  assign wb_master_rty_o = req & sl_rty;
  assign wb_master_dat_o = req ? sl_dat : '0;

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    timer_next = timer_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (any_match) begin
            state_next = ACTIVE;
            sel_next   = winner;
            timer_next = '0;
          end else begin
            state_next = DECERR;
          end
        end
      end
      ACTIVE: begin
        if (!wb_master_cyc_i)  state_next = IDLE;
        else if (term)         state_next = IDLE;
        else if (timeout_hit)  state_next = TOERR;
        else if (timer_reg != {TMR_W{1'b1}}) timer_next = timer_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign capture = !err_valid_reg && (state_reg != state_next) &&
                   ((state_next == DECERR) || (state_next == TOERR));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      timer_reg     <= '0;
      err_valid_reg <= 1'b0;
      err_addr_reg  <= '0;
      err_cause_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      timer_reg <= timer_next;
      if (err_clear) begin
        err_valid_reg <= 1'b0;
        err_addr_reg  <= '0;
        err_cause_reg <= 2'b00;
      end else if (capture) begin
        err_valid_reg <= 1'b1;
        err_addr_reg  <= wb_master_adr_i;
        err_cause_reg <= (state_next == DECERR) ? 2'b01 : 2'b10;
      end
    end
  end

  assign err_valid = err_valid_reg;
  assign err_addr  = err_addr_reg;
  assign err_cause = err_cause_reg;

endmodule

// File: tb/tb_wb_mux_n.sv
// Bench for wb_mux_n: directed scenarios plus randomized accesses, checked
// against a transaction-level model of decode, latency and error capture.
module tb_wb_mux_n;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int NS = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_dat = '0;
  logic          m_we = 1'b0;
  logic [SW-1:0] m_sel = '0;
  logic          m_stb = 1'b0;
  logic          m_cyc = 1'b0;
  logic          err_clear = 1'b0;
  logic [DW-1:0] wb_master_dat_o;
  logic          wb_master_ack_o, wb_master_err_o, wb_master_rty_o;
  logic [NS*AW-1:0] wb_slave_adr_o;
  logic [NS*DW-1:0] wb_slave_dat_o;
  logic [NS-1:0]    wb_slave_we_o, wb_slave_stb_o, wb_slave_cyc_o;
  logic [NS*SW-1:0] wb_slave_sel_o;
  logic [NS*DW-1:0] s_dat_flat;
  logic [NS-1:0]    s_ack = '0, s_err = '0, s_rty = '0;
  logic [NS*AW-1:0] wbs_addr, wbs_addr_msk;
  logic             err_valid;
  logic [AW-1:0]    err_addr;
  logic [1:0]       err_cause;

  logic [AW-1:0] base [NS];
  logic [AW-1:0] msk  [NS];
  logic [DW-1:0] s_dat [NS];

  always_comb begin
    wbs_addr     = '0;
    wbs_addr_msk = '0;
    s_dat_flat   = '0;
    for (int k = 0; k < NS; k++) begin
      wbs_addr[k*AW +: AW]     = base[k];
      wbs_addr_msk[k*AW +: AW] = msk[k];
      s_dat_flat[k*DW +: DW]   = s_dat[k];
    end
  end

  wb_mux_n #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .NUM_SLAVES(NS),
    .TIMEOUT_CYCLES(TO), .TMR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_master_adr_i(m_adr), .wb_master_dat_i(m_dat), .wb_master_we_i(m_we),
    .wb_master_sel_i(m_sel), .wb_master_stb_i(m_stb), .wb_master_cyc_i(m_cyc),
    .wb_master_dat_o(wb_master_dat_o), .wb_master_ack_o(wb_master_ack_o),
    .wb_master_err_o(wb_master_err_o), .wb_master_rty_o(wb_master_rty_o),
    .wb_slave_adr_o(wb_slave_adr_o), .wb_slave_dat_o(wb_slave_dat_o),
    .wb_slave_we_o(wb_slave_we_o), .wb_slave_sel_o(wb_slave_sel_o),
    .wb_slave_stb_o(wb_slave_stb_o), .wb_slave_cyc_o(wb_slave_cyc_o),
    .wb_slave_dat_i(s_dat_flat), .wb_slave_ack_i(s_ack),
    .wb_slave_err_i(s_err), .wb_slave_rty_i(s_rty),
    .wbs_addr(wbs_addr), .wbs_addr_msk(wbs_addr_msk),
    .err_valid(err_valid), .err_addr(err_addr), .err_cause(err_cause),
    .err_clear(err_clear)
  );

  int checks = 0;
  int failures = 0;

  // Reference error-capture state.
  logic          ev_m = 1'b0;
  logic [AW-1:0] ea_m = '0;
  logic [1:0]    ec_m = 2'b00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [AW-1:0] a);
    for (int k = 0; k < NS; k++)
      if (((a ^ base[k]) & msk[k]) == '0) return k;
    return -1;
  endfunction

  function automatic logic [NS-1:0] onehot(input int t);
    logic [NS-1:0] v;
    v = '0;
    if (t >= 0) v[t] = 1'b1;
    return v;
  endfunction

  task automatic model_error(input logic [AW-1:0] a, input logic [1:0] cause);
    if (!ev_m) begin
      ev_m = 1'b1;
      ea_m = a;
      ec_m = cause;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_stb"}, 64'(wb_slave_stb_o), 64'(0));
    chk({tag, "_cyc"}, 64'(wb_slave_cyc_o), 64'(0));
    chk({tag, "_resp"}, 64'({wb_master_ack_o, wb_master_err_o, wb_master_rty_o}), 64'(0));
    chk({tag, "_dat"}, 64'(wb_master_dat_o), 64'(0));
    chk({tag, "_ev"}, 64'(err_valid), 64'(ev_m));
    chk({tag, "_ea"}, 64'(err_addr), 64'(ea_m));
    chk({tag, "_ec"}, 64'(err_cause), 64'(ec_m));
  endtask

  // kind: 0 ack, 1 err, 2 rty, 3 ack+err, 4 never terminate
  task automatic run_access(input logic [AW-1:0] adr, input logic we, input int delay,
                            input int kind, input int spur);
    int t, other;
    logic fire, done;
    t = ref_decode(adr);
    for (int k = 0; k < NS; k++) s_dat[k] = $urandom;
    @(posedge clk); #1;
    m_adr = adr; m_we = we; m_dat = $urandom; m_sel = SW'($urandom);
    m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk);
    chk("req_stb0", 64'(wb_slave_stb_o), 64'(0));
    chk("req_resp0", 64'({wb_master_ack_o, wb_master_err_o}), 64'(0));
    other = int'($urandom_range(0, NS - 1));
    chk("bcast_adr", 64'(wb_slave_adr_o[other*AW +: AW]), 64'(adr));
    chk("bcast_sel", 64'(wb_slave_sel_o[other*SW +: SW]), 64'(m_sel));
    done = 1'b0;
    if (t < 0) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("dec_stb", 64'(wb_slave_stb_o), 64'(0));
      chk("dec_err", 64'({wb_master_ack_o, wb_master_err_o}), 64'(1));
      model_error(adr, 2'b01);
      done = 1'b1;
    end else begin
      for (int c = 0; c < TO && !done; c++) begin
        @(posedge clk); #1;
        s_ack = '0; s_err = '0; s_rty = '0;
        if (spur != 0) s_ack[(t + 1 + int'($urandom_range(0, NS - 2))) % NS] = 1'b1;
        fire = (kind != 4) && (c == delay);
        if (fire) begin
          if (kind == 0 || kind == 3) s_ack[t] = 1'b1;
          if (kind == 1 || kind == 3) s_err[t] = 1'b1;
          if (kind == 2) s_rty[t] = 1'b1;
        end
        @(negedge clk);
        chk("act_stb", 64'(wb_slave_stb_o), 64'(onehot(t)));
        chk("act_cyc", 64'(wb_slave_cyc_o), 64'(onehot(t)));
        chk("act_we", 64'(wb_slave_we_o), 64'(we ? onehot(t) : '0));
        chk("act_ack", 64'(wb_master_ack_o), 64'(fire && (kind == 0 || kind == 3)));
        chk("act_err", 64'(wb_master_err_o), 64'(fire && (kind == 1 || kind == 3)));
        chk("act_rty", 64'(wb_master_rty_o), 64'(fire && kind == 2));
        if (fire) chk("act_dat", 64'(wb_master_dat_o), 64'(s_dat[t]));
        done = fire;
      end
      if (!done) begin
        @(posedge clk); #1;
        s_ack = '0; s_err = '0; s_rty = '0;
        @(negedge clk);
        chk("to_stb", 64'(wb_slave_stb_o), 64'(0));
        chk("to_err", 64'({wb_master_ack_o, wb_master_err_o}), 64'(1));
        model_error(adr, 2'b10);
      end
    end
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0;
    s_ack = '0; s_err = '0; s_rty = '0;
    @(negedge clk);
    check_idle("post");
    $display("access adr=%08h we=%0d target=%0d kind=%0d delay=%0d", adr, we, t, kind, delay);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    ev_m = 1'b0; ea_m = '0; ec_m = 2'b00;
    @(negedge clk);
    check_idle("clr");
    $display("err_clear");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int kind, delay;
    for (int k = 0; k < NS; k++) begin
      base[k] = AW'(k) << 28;
      msk[k]  = 32'hF000_0000;
      s_dat[k] = '0;
    end
    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");
    $display("reset released");

    // Basic write to slave2, single-cycle ack
    run_access(32'h2000_0010, 1'b1, 0, 0, 0);

    // Overlapping maps: slave0 matches everything, wins over slave1
    msk[0] = '0;
    run_access(32'h1000_0000, 1'b0, 1, 0, 0);
    msk[0] = 32'hF000_0000;

    // Decode error
    run_access(32'hF000_0000, 1'b0, 0, 0, 0);

    // Timeout after clear, then a second error leaves capture intact
    do_clear();
    run_access(32'h1000_0040, 1'b1, 0, 4, 0);
    run_access(32'hF000_0100, 1'b0, 0, 0, 0);
    do_clear();

    // Spurious ack on an unselected slave
    run_access(32'h1000_0008, 1'b0, 2, 0, 1);

    // Abort mid-ACTIVE
    @(posedge clk); #1;
    m_adr = 32'h3000_0000; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_act", 64'(wb_slave_stb_o), 64'(4'b1000));
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    chk("abort_cyc0", 64'(wb_slave_cyc_o), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("abort");
    $display("abort adr=30000000");

    // Reset during ACTIVE clears error capture too
    run_access(32'hF000_0004, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    m_adr = 32'h0000_0020; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_act", 64'(wb_slave_stb_o), 64'(4'b0001));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
    ev_m = 1'b0; ea_m = '0; ec_m = 2'b00;
    @(negedge clk);
    check_idle("rst_mid");
    $display("reset during active");

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      a = {4'($urandom_range(0, 5)), 28'($urandom)};
      kind = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
      delay = int'($urandom_range(0, TO - 1));
      run_access(a, 1'($urandom), delay, kind, int'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) do_clear();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_mux_n.md
Name: wb_mux_n

Overview:
Parametrised N-port Wishbone address-decoding multiplexer; successor to the fixed 3-port mux. Sits between one Wishbone master (CPU data/instruction port) and NUM_SLAVES peripherals (SRAM, UART, timers, ...). Adds a registered decode stage that locks the target slave per access. It also adds per-access bus-timeout and decode-error responses, with sticky error capture for debug.

Parameters:
DATA_WIDTH, 32, data bus width (8/16/32/64)
ADDR_WIDTH, 32, address bus width
SELECT_WIDTH, DATA_WIDTH/8, byte-select width
NUM_SLAVES, 4, slave port count, 1..16
TIMEOUT_CYCLES, 255, max ACTIVE cycles without slave termination; 0 disables timeout
TMR_W, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
wb_master_adr_i / dat_i / we_i / sel_i / stb_i / cyc_i  in  ADDR_WIDTH / DATA_WIDTH / 1 / SELECT_WIDTH / 1 / 1  master request
wb_master_dat_o / ack_o / err_o / rty_o  out  DATA_WIDTH / 1 / 1 / 1  master response
wb_slave_adr_o / dat_o  out  NUM_SLAVES*ADDR_WIDTH / NUM_SLAVES*DATA_WIDTH  per-slave broadcast of master adr/dat; slice k = slave k
wb_slave_we_o / stb_o / cyc_o  out  NUM_SLAVES each  per-slave gated controls
wb_slave_sel_o  out  NUM_SLAVES*SELECT_WIDTH  per-slave byte select
wb_slave_dat_i  in  NUM_SLAVES*DATA_WIDTH  slave read data
wb_slave_ack_i / err_i / rty_i  in  NUM_SLAVES each  slave terminations
wbs_addr / wbs_addr_msk  in  NUM_SLAVES*ADDR_WIDTH each  per-slave prefix and mask
err_valid  out  1  sticky: an error was captured since clear
err_addr  out  ADDR_WIDTH  address of first captured error
err_cause  out  2  01 decode error, 10 timeout
err_clear  in  1  clears err_valid/err_addr/err_cause

Behaviour:
- Match k = ~|((adr ^ wbs_addr[k]) & wbs_addr_msk[k]). Priority: the lowest matching index wins.
- FSM states: IDLE, ACTIVE, DECERR, TOERR. Reset (rst_n=0 at clk edge) forces IDLE, sel_q=0, timer=0, err_valid=0, err_addr=0, err_cause=0.
- Outputs in IDLE and at reset: all slave stb/cyc/we=0, master ack/err/rty=0, master dat_o=0.
- IDLE, cyc_i&stb_i, with a match: sel_q<=winner, timer<=0, go ACTIVE.
- IDLE, cyc_i&stb_i, with no match: go DECERR.
- ACTIVE: slave sel_q gets cyc_o=cyc_i, stb_o=stb_i, we_o=we_i; all other slaves get 0. adr/dat/sel are broadcast to every slice unconditionally.
- ACTIVE responses: master ack/err/rty/dat come only from slave sel_q, ANDed with cyc_i&stb_i. Terminations from unselected slaves are ignored.
- Latency: slave stb rises 1 cycle after master stb. A slave's combinational ack reaches the master in that same cycle.
- ACTIVE, termination (ack|err|rty of sel_q while stb_i): go IDLE. The next access re-decodes, so minimum throughput is 1 access per 2 cycles.
- ACTIVE, cyc_i=0: abort and go IDLE with no response.
- ACTIVE, no termination: timer increments each cycle. When TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 without termination, go TOERR.
- DECERR / TOERR: all slave cyc/stb=0. master err_o=cyc_i&stb_i for exactly 1 cycle, then IDLE. If cyc_i has already dropped, the state still returns to IDLE silently.
- Error capture: on entry to DECERR/TOERR with err_valid=0, latch the master adr and cause, and set err_valid. Later errors do not overwrite.
- err_clear has priority over a same-cycle capture. Timer saturates and never wraps.
- Simultaneous ack and err from the selected slave: both are forwarded; the master treats err as dominant.

Test Plan:
- NUM_SLAVES=4, slave k addr=k<<28, msk=0xF0000000. Write 0x2000_0010 -> only slave2 stb rises 1 cycle after master stb; slave2 ack -> master ack same cycle; FSM back to IDLE.
- Overlapping maps: slave0 msk=0, slave1 matches 0x1xxxxxxx. Read 0x1000_0000 -> slave0 selected, slave1 stb stays 0.
- Address 0xF000_0000 with no match -> no slave strobed; master err_o=1 for 1 cycle 1 cycle after stb; err_valid=1, err_addr=0xF0000000, err_cause=01.
- TIMEOUT_CYCLES=8, slave never acks -> slave stb is high for 8 cycles, then drops; master err pulses once; err_cause=10. A second error leaves err_addr unchanged; err_clear zeroes all three error outputs.
- Spurious ack on slave3 while slave1 is selected -> master ack stays 0. Master drops cyc mid-ACTIVE -> all slave cyc=0 next cycle, no err.
- rst_n=0 during ACTIVE -> next cycle all slave stb/cyc=0, master outputs 0, FSM IDLE, err_valid=0.
